mux_4: RTL and testbench
========================

// Module: mux_4
// PURPOSE
//   4:1 multiplexer with a registered output. Selects one of four data
//   inputs (a, b, c, d) using a 2-bit select s.
//   Serves as a generic selection primitive in datapath and control logic.
//   A combinational output is also provided for paths that need zero latency.
// PARAMETERS
//   WIDTH      1    data width of a, b, c, d, out and out_comb (WIDTH >= 1)
//   RST_VAL    0    value loaded into out on reset (WIDTH bits, zero-extended)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   out        out  WIDTH  registered selected data
//   a          in   WIDTH  data input, selected when s == 2'b00
//   b          in   WIDTH  data input, selected when s == 2'b01
//   c          in   WIDTH  data input, selected when s == 2'b10
//   d          in   WIDTH  data input, selected when s == 2'b11
//   s          in   2      select
//   out_comb   out  WIDTH  combinational selected data, no register
// BEHAVIOUR
//   - Select map: 00->a, 01->b, 10->c, 11->d. Only the selected input affects
//     the outputs; changes on the other inputs have no effect.
//   - out_comb follows a/b/c/d/s combinationally, with zero cycles of latency.
//   - out is updated at each rising clk edge with out_comb. Latency is 1 cycle.
//     out holds its value between edges.
//   - Reset (rst=1 at a rising edge): out <= RST_VAL. Reset has priority over
//     the data path. out_comb is not affected by rst.
//   - Reset asserted mid-stream clears out on that edge. On the first edge
//     after rst deasserts, out captures the current selection.
//   - X/Z on s: out_comb is X. No X-pessimism fix-up is required.
//   - No handshake and no enable: out updates every cycle.
//   - Before the first reset, the power-up value of out is undefined.
//   - Width rule: all data ports are exactly WIDTH bits. There is no
//     truncation and no extension inside the data path.
// TESTING
//   1. rst=1 for 2 cycles, inputs random -> out==RST_VAL. out_comb matches
//      the select map throughout.
//   2. WIDTH=1, a=1, b=c=d=0, s=00 -> out_comb=1, and out=1 one cycle later.
//      Then a=0 -> out=0.
//   3. Walk s over 00,01,10,11 with only the matching input =1 -> out=1
//      each cycle, delayed by 1 cycle. Same walk with only a non-matching
//      input =1 -> out=0.
//   4. s=11, a=b=c=1, d=0 -> out=0. Then d=1 -> out=1 on the next edge.
//   5. WIDTH=8: a=8'h11, b=8'h22, c=8'h33, d=8'h44, s toggled each cycle
//      -> out shows the prior cycle's pick.
//   6. Assert rst for 1 cycle in the middle of test 5 -> out=RST_VAL for that
//      cycle, and the correct value resumes on the next edge.

Source files
------------

// File: rtl/mux_4.sv
// mux_4: 4:1 multiplexer with combinational and registered outputs
module mux_4 #(
   parameter int unsigned      WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       s,
   output logic [WIDTH-1:0] out_comb,
   output logic [WIDTH-1:0] out
);
   logic [WIDTH-1:0] r_out;
   always_comb out_comb = s[1] ? (s[0] ? d : c) : (s[0] ? b : a);
   always_ff @(posedge clk)
      if (rst) r_out <= RST_VAL;
      else     r_out <= out_comb;
   assign out = r_out;
endmodule

// File: tb/tb_mux_4.sv
// tb_mux_4: randomized self-checking bench for mux_4 at WIDTH=1 and WIDTH=8
module tb_mux_4;
   localparam logic [7:0] RST8 = 8'h5A;
   logic       clk = 1'b0, rst = 1'b0;
   logic [1:0] s = 2'b00;
   logic [7:0] a8 = '0, b8 = '0, c8 = '0, d8 = '0;
   logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, d1 = 1'b0;
   logic [7:0] out8, oc8;
   logic       out1, oc1;
   int         passed = 0, total = 0;

   always #5 clk = ~clk;

   mux_4 #(.WIDTH(8), .RST_VAL(RST8)) u8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .d(d8), .s(s), .out_comb(oc8), .out(out8));
   mux_4 #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .d(d1), .s(s), .out_comb(oc1), .out(out1));

   // reference: the select value names which of the four inputs is chosen
   function automatic logic [7:0] pick(input logic [7:0] a, b, c, d, input logic [1:0] sel);
      logic [7:0] v [4];
      v = '{a, b, c, d};
      return v[sel];
   endfunction

   task automatic set8(input logic [7:0] a, b, c, d, input logic [1:0] sel);
      a8 = a; b8 = b; c8 = c; d8 = d; s = sel; #1;
   endtask

   task automatic set1(input logic a, b, c, d, input logic [1:0] sel);
      a1 = a; b1 = b; c1 = c; d1 = d; s = sel; #1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         set8($urandom, $urandom, $urandom, $urandom, 2'($urandom));
         set1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), s);
         e = pick(a8, b8, c8, d8, s);
         total++; if (oc8 !== e) $display("FAIL reset_comb8 got %h want %h", oc8, e); else passed++;
         tick();
         total++; if (out8 !== RST8) $display("FAIL reset_out8 got %h want %h", out8, RST8); else passed++;
         total++; if (out1 !== 1'b0) $display("FAIL reset_out1 got %b want 0", out1); else passed++;
      end
      rst = 1'b0;
   endtask

   task automatic test_width1();
      set1(1, 0, 0, 0, 2'b00);
      total++; if (oc1 !== 1'b1) $display("FAIL w1_comb got %b want 1", oc1); else passed++;
      total++; if (out1 !== 1'b0) $display("FAIL w1_latency got %b want 0", out1); else passed++;
      tick();
      total++; if (out1 !== 1'b1) $display("FAIL w1_out got %b want 1", out1); else passed++;
      set1(0, 0, 0, 0, 2'b00);
      tick();
      total++; if (out1 !== 1'b0) $display("FAIL w1_clear got %b want 0", out1); else passed++;
   endtask

   task automatic test_walk();
      logic [3:0] hot;
      for (int k = 0; k < 4; k++) begin
         hot = 4'b1 << k;
         set1(hot[0], hot[1], hot[2], hot[3], 2'(k));
         set8({8{hot[0]}}, {8{hot[1]}}, {8{hot[2]}}, {8{hot[3]}}, 2'(k));
         total++; if (oc1 !== 1'b1) $display("FAIL walk_comb s=%0d got %b want 1", k, oc1); else passed++;
         tick();
         total++; if (out1 !== 1'b1) $display("FAIL walk_hit s=%0d got %b want 1", k, out1); else passed++;
         total++; if (out8 !== 8'hFF) $display("FAIL walk_hit8 s=%0d got %h want ff", k, out8); else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         hot = 4'b1 << ((k + 1) % 4);
         set1(hot[0], hot[1], hot[2], hot[3], 2'(k));
         set8({8{hot[0]}}, {8{hot[1]}}, {8{hot[2]}}, {8{hot[3]}}, 2'(k));
         tick();
         total++; if (out1 !== 1'b0) $display("FAIL walk_miss s=%0d got %b want 0", k, out1); else passed++;
         total++; if (out8 !== 8'h00) $display("FAIL walk_miss8 s=%0d got %h want 00", k, out8); else passed++;
      end
   endtask

   task automatic test_sel_d();
      set1(1, 1, 1, 0, 2'b11);
      tick();
      total++; if (out1 !== 1'b0) $display("FAIL seld_zero got %b want 0", out1); else passed++;
      set1(1, 1, 1, 1, 2'b11);
      total++; if (out1 !== 1'b0) $display("FAIL seld_hold got %b want 0", out1); else passed++;
      tick();
      total++; if (out1 !== 1'b1) $display("FAIL seld_one got %b want 1", out1); else passed++;
   endtask

   task automatic test_toggle_reset();
      logic [7:0] e;
      for (int i = 0; i < 10; i++) begin
         rst = (i == 5);
         set8(8'h11, 8'h22, 8'h33, 8'h44, 2'(i));
         e = rst ? RST8 : pick(8'h11, 8'h22, 8'h33, 8'h44, 2'(i));
         tick();
         total++; if (out8 !== e) $display("FAIL toggle cyc=%0d got %h want %h", i, out8, e); else passed++;
      end
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] e, ec;
      for (int i = 0; i < 60; i++) begin
         rst = ($urandom_range(0, 9) == 0);
         set8($urandom, $urandom, $urandom, $urandom, 2'($urandom));
         ec = pick(a8, b8, c8, d8, s);
         e = rst ? RST8 : ec;
         total++; if (oc8 !== ec) $display("FAIL rand_comb cyc=%0d got %h want %h", i, oc8, ec); else passed++;
         tick();
         total++; if (out8 !== e) $display("FAIL rand_out cyc=%0d got %h want %h", i, out8, e); else passed++;
         a8 = ~a8; b8 = ~b8; c8 = ~c8; d8 = ~d8; #2;
         total++; if (out8 !== e) $display("FAIL rand_hold cyc=%0d got %h want %h", i, out8, e); else passed++;
      end
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_width1();
      test_walk();
      test_sel_d();
      test_toggle_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
